// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and receiver lock states shared by the VGA transmitter and receiver
package vga_timing_pkg;
    localparam int HPIXELS = 800;
    localparam int VLINES  = 521;
    localparam int HPULSE  = 96;
    localparam int VPULSE  = 2;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VBP     = 31;
    localparam int VFP     = 511;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rx_state_t;
endpackage

// File: rtl/vga_lock_fsm.sv
// vga_lock_fsm: frame-lock state machine that needs LOCK_FRAMES clean frames before declaring lock
module vga_lock_fsm
    import vga_timing_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic      clk_25Mhz_vr,
    input  logic      rst_vr,
    input  logic      vs_fall,
    input  logic      err_this_cycle,
    output rx_state_t state,
    output logic      locked,
    output logic      frame_start
);
    rx_state_t  state_nxt;
    logic [3:0] good_cnt, good_cnt_nxt;
    // state, clean-frame counter and registered status pulses
    always_ff @(posedge clk_25Mhz_vr) begin
        if (rst_vr) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_cnt_nxt;
            locked      <= state_nxt == LOCKED;
            frame_start <= state == LOCKED && vs_fall && !err_this_cycle;
        end
    end
    // find a frame edge, count clean frames, fall back to search on any violation
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            ACQUIRE: begin
                if (err_this_cycle) state_nxt = SEARCH;
                else if (vs_fall) begin
                    good_cnt_nxt = good_cnt + 4'd1;
                    state_nxt    = good_cnt_nxt == 4'(LOCK_FRAMES) ? LOCKED : ACQUIRE;
                end
            end
            LOCKED:  state_nxt = err_this_cycle ? SEARCH : LOCKED;
            default: state_nxt = SEARCH;
        endcase
    end
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers raster position from hsync/vsync, checks timing and tracks lock; VGA_RX_FRAME_SUM_EN adds a per-frame colour checksum
module vga_sync_receiver #(
    parameter int HPIXELS     = vga_timing_pkg::HPIXELS,
    parameter int VLINES      = vga_timing_pkg::VLINES,
    parameter int HPULSE      = vga_timing_pkg::HPULSE,
    parameter int VPULSE      = vga_timing_pkg::VPULSE,
    parameter int HBP         = vga_timing_pkg::HBP,
    parameter int HFP         = vga_timing_pkg::HFP,
    parameter int VBP         = vga_timing_pkg::VBP,
    parameter int VFP         = vga_timing_pkg::VFP,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25Mhz_vr,
    input  logic        rst_vr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic [9:0]  hc_rx,
    output logic [9:0]  vc_rx,
    output logic [9:0]  x_rx,
    output logic [9:0]  y_rx,
    output logic        pixel_valid,
    output logic [2:0]  pix_r,
    output logic [2:0]  pix_g,
    output logic [1:0]  pix_b,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_sum
);
    import vga_timing_pkg::*;
    localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST = 10'(VLINES - 1);
    localparam logic [9:0] H_PW   = 10'(HPULSE - 1);
    localparam logic [9:0] V_PW   = 10'(VPULSE - 1);
    localparam logic [9:0] H_BP   = 10'(HBP);
    localparam logic [9:0] H_FP   = 10'(HFP);
    localparam logic [9:0] V_BP   = 10'(VBP);
    localparam logic [9:0] V_FP   = 10'(VFP);
    logic      hs_d, vs_d, hs_fall, hs_rise, vs_fall, vs_rise, err_this_cycle;
    rx_state_t state;
    // sync edges and timing violations; nothing is checked until a frame edge has been seen
    always_comb begin
        hs_fall        = hs_d & ~hsync_in;
        hs_rise        = ~hs_d & hsync_in;
        vs_fall        = vs_d & ~vsync_in;
        vs_rise        = ~vs_d & vsync_in;
        err_this_cycle = (state != SEARCH) & (
            (hs_fall & (hc_rx != H_LAST)) |
            (hs_rise & (hc_rx != H_PW)) |
            (vs_fall & (vc_rx != V_LAST)) |
            (vs_rise & (vc_rx != V_PW)) |
            ((vs_fall | vs_rise) & ~hs_fall) |
            (~hs_fall & (hc_rx == 10'd1022)));
    end
    // counters track the transmitter one clock late; colour is registered to stay aligned with them
    always_ff @(posedge clk_25Mhz_vr) begin
        if (rst_vr) begin
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            hc_rx    <= '0;
            vc_rx    <= '0;
            pix_r    <= '0;
            pix_g    <= '0;
            pix_b    <= '0;
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            hs_d     <= hsync_in;
            vs_d     <= vsync_in;
            hc_rx    <= hs_fall ? '0 : (hc_rx == 10'h3FF ? hc_rx : hc_rx + 10'd1);
            if (hs_fall) vc_rx <= vs_fall ? '0 : (vc_rx == 10'h3FF ? vc_rx : vc_rx + 10'd1);
            pix_r    <= red_in;
            pix_g    <= green_in;
            pix_b    <= blue_in;
            sync_err <= err_this_cycle;
            err_cnt  <= err_cnt + {7'd0, err_this_cycle && err_cnt != 8'hFF};
        end
    end
    assign pixel_valid = locked && hc_rx >= H_BP && hc_rx < H_FP && vc_rx >= V_BP && vc_rx < V_FP;
    assign x_rx        = hc_rx - H_BP;
    assign y_rx        = vc_rx - V_BP;
    vga_lock_fsm #(.LOCK_FRAMES(LOCK_FRAMES)) u_fsm (
        .clk_25Mhz_vr  (clk_25Mhz_vr),
        .rst_vr        (rst_vr),
        .vs_fall       (vs_fall),
        .err_this_cycle(err_this_cycle),
        .state         (state),
        .locked        (locked),
        .frame_start   (frame_start)
    );
`ifdef VGA_RX_FRAME_SUM_EN
    logic [15:0] acc;
    // sum active-window colour, publish at frame start, discard a frame that saw an error
    always_ff @(posedge clk_25Mhz_vr) begin
        if (rst_vr) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (err_this_cycle) begin
            acc <= '0;
        end else if (frame_start) begin
            frame_sum <= acc;
            acc       <= '0;
        end else if (pixel_valid) begin
            acc <= acc + {8'd0, pix_r, pix_g, pix_b};
        end
    end
`else
    assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed checks of the VGA receiver on a reduced raster driven by a transmitter model
module tb_vga_sync_receiver;
    localparam int H = 40, V = 30, HPW = 5, VPW = 2, HB = 8, HF = 36, VB = 4, VF = 26;
    logic        clk_25Mhz_vr = 1'b0;
    logic        rst_vr, hsync_in, vsync_in;
    logic [2:0]  red_in, green_in, pix_r, pix_g;
    logic [1:0]  blue_in, pix_b;
    logic [9:0]  hc_rx, vc_rx, x_rx, y_rx;
    logic        pixel_valid, locked, frame_start, sync_err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_sum;
    int n_checks = 0, n_errors = 0;
    int tx_hc, tx_vc, line_end, exp_err, pulses, exp_sum;
    logic hs_ovr_en, hs_ovr_val, vs_ovr_en, vs_ovr_val;

    vga_sync_receiver #(
        .HPIXELS(H), .VLINES(V), .HPULSE(HPW), .VPULSE(VPW),
        .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(2)
    ) dut (
        .clk_25Mhz_vr(clk_25Mhz_vr), .rst_vr(rst_vr),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hc_rx(hc_rx), .vc_rx(vc_rx), .x_rx(x_rx), .y_rx(y_rx),
        .pixel_valid(pixel_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .locked(locked), .frame_start(frame_start), .sync_err(sync_err),
        .err_cnt(err_cnt), .frame_sum(frame_sum)
    );

    always #20 clk_25Mhz_vr = ~clk_25Mhz_vr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic act;
        act = tx_hc >= HB && tx_hc < HF && tx_vc >= VB && tx_vc < VF;
        hsync_in = hs_ovr_en ? hs_ovr_val : (tx_hc >= HPW);
        vsync_in = vs_ovr_en ? vs_ovr_val : (tx_vc >= VPW);
        {red_in, green_in, blue_in} = act ? 8'hFF : 8'h5A;
        @(posedge clk_25Mhz_vr);
        #1;
        if (tx_hc == line_end) begin
            tx_hc    = 0;
            line_end = H - 1;
            tx_vc    = (tx_vc == V - 1) ? 0 : tx_vc + 1;
        end else tx_hc++;
    endtask

    task automatic run_to(input int hc, input int vc);
        int n = 0;
        while (!(tx_hc == hc && tx_vc == vc) && n < 4 * H * V) begin
            step();
            n++;
        end
        check("reach_position", tx_hc == hc && tx_vc == vc, 1);
    endtask

    task automatic relock();
        run_to(0, 0); step();
        run_to(0, 0); step();
        run_to(0, 0); check("prelock_locked", locked, 0);
        step();       check("lock_locked", locked, 1);
    endtask

    task automatic check_cleared();
        check("rst_hc_rx", hc_rx, 0);
        check("rst_vc_rx", vc_rx, 0);
        check("rst_pix", {pix_r, pix_g, pix_b}, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_sum", frame_sum, 0);
    endtask

    initial begin
`ifdef VGA_RX_FRAME_SUM_EN
        exp_sum = ((HF - HB) * (VF - VB) * 255) & 16'hFFFF;
`else
        exp_sum = 0;
`endif
        rst_vr = 1'b1; hs_ovr_en = 1'b0; hs_ovr_val = 1'b1; vs_ovr_en = 1'b0; vs_ovr_val = 1'b1;
        tx_hc = 10; tx_vc = 5; line_end = H - 1; exp_err = 0;
        repeat (3) step();
        check_cleared();
        rst_vr = 1'b0;

        relock();
        check("lock_err_cnt", err_cnt, 0);
        check("lock_no_frame_start", frame_start, 0);
        run_to(HB, VB - 1); step(); check("pv_above_window", pixel_valid, 0);
        run_to(HB - 1, VB); step(); check("pv_left_of_window", pixel_valid, 0);
        check("pix_blank", {pix_r, pix_g, pix_b}, 8'h5A);
        step();
        check("pv_first", pixel_valid, 1);
        check("x_first", x_rx, 0);
        check("y_first", y_rx, 0);
        check("hc_first", hc_rx, HB);
        check("vc_first", vc_rx, VB);
        check("pix_active", {pix_r, pix_g, pix_b}, 8'hFF);
        run_to(HF - 1, VF - 1); step();
        check("pv_last", pixel_valid, 1);
        check("x_last", x_rx, HF - HB - 1);
        check("y_last", y_rx, VF - VB - 1);
        step(); check("pv_right_of_window", pixel_valid, 0);
        run_to(0, 0); step();
        check("frame_start_1", frame_start, 1);
        check("fs_vc_rx", vc_rx, 0);
        check("fs_hc_rx", hc_rx, 0);
        step(); check("frame_start_pulse", frame_start, 0);
        run_to(0, 0); step(); check("frame_start_2", frame_start, 1);
        step(); check("frame_sum", frame_sum, exp_sum);

        run_to(0, 10); line_end = H - 2;
        run_to(0, 11); step(); exp_err++;
        check("short_sync_err", sync_err, 1);
        check("short_err_cnt", err_cnt, exp_err);
        check("short_locked", locked, 0);
        step(); check("short_pulse", sync_err, 0);
        relock();

        run_to(HPW, 2);
        hs_ovr_en = 1'b1; hs_ovr_val = 1'b1; pulses = 0;
        repeat (1100) begin step(); pulses += int'(sync_err); end
        hs_ovr_en = 1'b0; exp_err++;
        check("lost_pulses", pulses, 1);
        check("lost_hc_sat", hc_rx, 10'h3FF);
        check("lost_locked", locked, 0);
        check("lost_err_cnt", err_cnt, exp_err);
        relock();

        run_to(0, 0);
        vs_ovr_en = 1'b1; vs_ovr_val = 1'b1; pulses = 0;
        repeat (5) begin step(); pulses += int'(sync_err); end
        vs_ovr_en = 1'b0;
        check("misalign_quiet", pulses, 0);
        step(); exp_err++;
        check("misalign_sync_err", sync_err, 1);
        check("misalign_err_cnt", err_cnt, exp_err);
        check("misalign_locked", locked, 0);
        check("misalign_no_frame_start", frame_start, 0);

        run_to(0, 0); step();
        run_to(HPW - 1, 5);
        hs_ovr_en = 1'b1; hs_ovr_val = 1'b1; step(); hs_ovr_en = 1'b0; exp_err++;
        check("width_sync_err", sync_err, 1);
        check("width_err_cnt", err_cnt, exp_err);

        relock();
        run_to(20, 10);
        check("midframe_locked", locked, 1);
        rst_vr = 1'b1; step();
        check_cleared();
        rst_vr = 1'b0;

        hs_ovr_en = 1'b1; hs_ovr_val = 1'b1; vs_ovr_en = 1'b1; pulses = 0;
        for (int i = 0; i < 700; i++) begin
            vs_ovr_val = i[0];
            step();
            pulses += int'(sync_err);
        end
        check("sat_pulses", pulses >= 300, 1);
        check("sat_err_cnt", err_cnt, 255);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            vs_ovr_val = i[0];
            step();
            pulses += int'(sync_err);
        end
        check("sat_still_erroring", pulses > 0, 1);
        check("sat_err_cnt_hold", err_cnt, 255);
        hs_ovr_en = 1'b0; vs_ovr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
